// File: rtl/even_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | even_seq_pkg : shared state encoding and constants for even_seq_ctrl |
// | Revision 1.0 : initial release                                       |
// +----------------------------------------------------------------------+
package even_seq_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;
   localparam int   STEP   = 2;

endpackage
`default_nettype wire

// File: rtl/even_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | even_step : next even value and bound detection for one step         |
// | Revision 1.0 : initial release                                       |
// +----------------------------------------------------------------------+
module even_step
   import even_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] value,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] hi,
   input  logic             dir,
   output logic [WIDTH-1:0] nxt,
   output logic             at_bound
);

   localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);

   // Bound is checked before stepping so the modular wrap of value+/-2 is never selected.
   always_comb begin
      at_bound = (dir == DIR_DN) ? (value == lo) : (value == hi);
      if (at_bound)
         nxt = (dir == DIR_DN) ? hi : lo;
      else
         nxt = (dir == DIR_DN) ? (value - C_STEP) : (value + C_STEP);
   end

endmodule
`default_nettype wire

// File: rtl/even_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | even_seq_ctrl : sequenced, back-pressurable even-number stream       |
// | Revision 1.0 : initial release                                       |
// +----------------------------------------------------------------------+
module even_seq_ctrl
   import even_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             halt,
   input  logic [WIDTH-1:0] cfg_lo,
   input  logic [WIDTH-1:0] cfg_hi,
   input  logic             cfg_dir,
   input  logic             cfg_wrap,
   output logic [WIDTH-1:0] out_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] xfer_cnt
);

   localparam logic [WIDTH-1:0] C_EVEN_MASK = ~WIDTH'(1);

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_hi;
   logic             r_dir;
   logic             r_wrap;
   logic [WIDTH-1:0] r_value;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_mlo;
   logic [WIDTH-1:0] w_mhi;
   logic [WIDTH-1:0] w_nxt;
   logic             w_at_bound;
   logic             w_xfer;

   assign w_mlo  = cfg_lo & C_EVEN_MASK;
   assign w_mhi  = cfg_hi & C_EVEN_MASK;
   assign w_xfer = r_valid & out_ready;

   even_step #(.WIDTH(WIDTH)) u_step (
      .value    (r_value),
      .lo       (r_lo),
      .hi       (r_hi),
      .dir      (r_dir),
      .nxt      (w_nxt),
      .at_bound (w_at_bound)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_lo    <= '0;
         r_hi    <= '0;
         r_dir   <= 1'b0;
         r_wrap  <= 1'b0;
         r_value <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start && !halt) begin
                  if (w_mlo > w_mhi) begin
                     r_err <= 1'b1;
                  end else begin
                     r_lo    <= w_mlo;
                     r_hi    <= w_mhi;
                     r_dir   <= cfg_dir;
                     r_wrap  <= cfg_wrap;
                     r_value <= (cfg_dir == DIR_UP) ? w_mlo : w_mhi;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               // A transfer coinciding with halt is still counted.
               if (w_xfer && !(&r_cnt))
                  r_cnt <= r_cnt + 1'b1;
               if (halt) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else if (w_xfer) begin
                  if (w_at_bound && !r_wrap) begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end else begin
                     r_value <= w_nxt;
                  end
               end
            end
            FIN: begin
               r_state <= IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign out_value = r_value;
   assign out_valid = r_valid;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_even_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_even_seq_ctrl : scoreboard bench for even_seq_ctrl                 |
// | Revision 1.0 : initial release                                       |
// +----------------------------------------------------------------------+
module tb_even_seq_ctrl;

   localparam int WIDTH = 4;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             halt;
   logic [WIDTH-1:0] cfg_lo;
   logic [WIDTH-1:0] cfg_hi;
   logic             cfg_dir;
   logic             cfg_wrap;
   logic [WIDTH-1:0] out_value;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] xfer_cnt;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   even_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .halt      (halt),
      .cfg_lo    (cfg_lo),
      .cfg_hi    (cfg_hi),
      .cfg_dir   (cfg_dir),
      .cfg_wrap  (cfg_wrap),
      .out_value (out_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .xfer_cnt  (xfer_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_xfer", int'(out_value), -1);
         end else begin
            chk("stream_value", int'(out_value), exp_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int lo, input int hi, input logic dir, input logic wrap);
      cfg_lo   = WIDTH'(lo);
      cfg_hi   = WIDTH'(hi);
      cfg_dir  = dir;
      cfg_wrap = wrap;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input string name, input int maxc, output int n);
      n = 0;
      while (!done && n < maxc) begin
         tick();
         n++;
      end
      chk(name, int'(done), 1);
   endtask

   initial begin
      int n;
      bit saw_done;

      rst = 1'b1; start = 1'b0; halt = 1'b0; out_ready = 1'b1;
      cfg_lo = '0; cfg_hi = '0; cfg_dir = 1'b0; cfg_wrap = 1'b0;
      tick(); tick();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_value", int'(out_value), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_cnt", int'(xfer_cnt), 0);
      rst = 1'b0;
      tick();

      // Full up run 0..14, one-shot
      for (int v = 0; v <= 14; v += 2) exp_q.push_back(v);
      do_start(0, 14, 1'b0, 1'b0);
      chk("t1_first_valid", int'(out_valid), 1);
      chk("t1_busy", int'(busy), 1);
      wait_done("t1_done", 20, n);
      chk("t1_cycles", n, 8);
      chk("t1_cnt", int'(xfer_cnt), 8);
      chk("t1_busy_fin", int'(busy), 0);
      tick();
      chk("t1_done_pulse", int'(done), 0);
      chk("t1_busy_after", int'(busy), 0);

      // Down run with wrap, masked 2..8, halted together with a transfer
      begin
         int seq[10] = '{8, 6, 4, 2, 8, 6, 4, 2, 8, 6};
         foreach (seq[i]) exp_q.push_back(seq[i]);
      end
      do_start(3, 9, 1'b1, 1'b1);
      saw_done = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (done) saw_done = 1'b1;
      end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      if (done) saw_done = 1'b1;
      chk("t2_no_done", int'(saw_done), 0);
      chk("t2_halt_valid", int'(out_valid), 0);
      chk("t2_halt_busy", int'(busy), 0);
      chk("t2_halt_cnt", int'(xfer_cnt), 10);
      tick();
      chk("t2_idle_done", int'(done), 0);

      // Back-pressure: ready 1,0,0,1,0,0,...
      for (int v = 0; v <= 6; v += 2) exp_q.push_back(v);
      do_start(0, 6, 1'b0, 1'b0);
      n = 0;
      while (!done && n < 40) begin
         out_ready = (n % 3 == 0);
         tick();
         n++;
      end
      out_ready = 1'b1;
      chk("t3_done", int'(done), 1);
      chk("t3_cnt", int'(xfer_cnt), 4);
      tick();

      // Inverted bounds raise err only
      do_start(10, 4, 1'b0, 1'b0);
      chk("t4_err", int'(err), 1);
      chk("t4_valid", int'(out_valid), 0);
      chk("t4_busy", int'(busy), 0);
      tick();
      chk("t4_err_pulse", int'(err), 0);
      chk("t4_busy2", int'(busy), 0);

      // halt wins over start in IDLE
      halt = 1'b1;
      do_start(0, 4, 1'b0, 1'b0);
      halt = 1'b0;
      chk("t4b_halt_start_busy", int'(busy), 0);
      chk("t4b_halt_start_valid", int'(out_valid), 0);

      // Reset while value 6 is presented
      exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(4);
      do_start(0, 14, 1'b0, 1'b0);
      tick(); tick(); tick();
      chk("t5_pre_value", int'(out_value), 6);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_value", int'(out_value), 0);
      chk("t5_valid", int'(out_valid), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_cnt", int'(xfer_cnt), 0);
      chk("t5_done", int'(done), 0);
      chk("t5_err", int'(err), 0);
      exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(8);
      do_start(4, 8, 1'b0, 1'b0);
      wait_done("t5_restart_done", 20, n);
      chk("t5_restart_cnt", int'(xfer_cnt), 3);
      tick();

      // Single-value run lo == hi
      exp_q.push_back(6);
      do_start(6, 6, 1'b0, 1'b0);
      wait_done("t6_done", 10, n);
      chk("t6_cycles", n, 1);
      chk("t6_cnt", int'(xfer_cnt), 1);
      tick();

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/even_seq_ctrl.md
Name: even_seq_ctrl

Overview:
Controller that sequences an even-number generator datapath. It produces a configurable run of even values over a valid/ready stream:
- bounds lo..hi, counting up or down
- one-shot or wrap-around
- start/halt control and done/error status

It sits between the software-visible control bits and the downstream consumer of the even-number stream. It replaces free-running generation with a sequenced, back-pressurable source.

Parameters:
WIDTH, 4, bit width of bounds and output value (WIDTH >= 2)
CNT_W, 8, width of transfer counter (saturating)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  pulse; latches config and begins a run when IDLE
halt  in  1  abort the current run; wins over start
cfg_lo  in  WIDTH  lower bound; bit 0 forced to 0 on latch
cfg_hi  in  WIDTH  upper bound; bit 0 forced to 0 on latch
cfg_dir  in  1  0 = count up from lo, 1 = count down from hi
cfg_wrap  in  1  1 = reload at bound, 0 = finish at bound
out_value  out  WIDTH  current even value
out_valid  out  1  out_value is valid
out_ready  in  1  consumer accepts when out_valid & out_ready
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the last transfer of a one-shot run
err  out  1  one-cycle pulse on start with masked lo > masked hi
xfer_cnt  out  CNT_W  transfers accepted in the current run; saturates at all-ones

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE
  - out_value=0, out_valid=0, busy=0, done=0, err=0, xfer_cnt=0
  - latched config cleared to lo=0, hi=0, dir=0, wrap=0
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1, halt=0, masked lo<=hi: latch config. Next cycle: RUN, out_valid=1, out_value = lo (dir=0) or hi (dir=1), xfer_cnt=0.
  - start=1, masked lo>hi: err=1 for one cycle, stay IDLE, latched config unchanged.
  - start with halt=1: ignored.
- RUN:
  - out_value and out_valid hold stable while out_valid & ~out_ready.
  - On transfer, xfer_cnt increments (saturating) and out_value advances by 2 (up) or -2 (down) the next cycle.
  - Transfer at the bound (hi for up, lo for down):
    - wrap=1: next out_value = start value, remain RUN.
    - wrap=0: next cycle state=FIN, out_valid=0.
  - lo==hi: every value is the bound. Single-value run, or a repeated constant when wrap=1.
  - Arithmetic is WIDTH-bit. The bound check precedes the increment, so no modular overflow is ever output (e.g. WIDTH=4, hi=14: never emits 0 via overflow).
  - start in RUN: ignored; config is not re-latched mid-run.
  - halt=1 (any cycle in RUN): next cycle IDLE, out_valid=0, no done. A transfer in the same cycle as halt still counts in xfer_cnt.
- FIN: done=1 for exactly that cycle, busy=0, then IDLE. A start during FIN is ignored.
- busy = (state==RUN), registered with the state.
- xfer_cnt holds its value in IDLE/FIN until the next accepted start.
- rst mid-run: immediate return to reset values at that edge; no done, no err.
- Latency: start to first out_valid is 1 cycle. Each transfer to the next value is 0 bubble cycles, giving full throughput of 1 value/cycle with out_ready=1.

Decomposition:
- Shared package even_seq_pkg:
  - state enum {IDLE, RUN, FIN}
  - constants DIR_UP=0, DIR_DN=1, STEP=2
- Sub-module even_step: combinational next-value/at-bound logic.
  - Inputs: value, lo, hi, dir.
  - Outputs: nxt, at_bound.
  - Reused by the verification model.
- All sequential logic stays in even_seq_ctrl.

Test Plan:
- WIDTH=4, lo=0, hi=14, dir=0, wrap=0, out_ready=1, start pulse -> out_value 0,2,4,...,14 on consecutive cycles; done pulses the cycle after 14 is accepted; xfer_cnt=8; busy low afterwards.
- lo=3, hi=9, dir=1, wrap=1, out_ready=1 -> masked bounds 2..8; sequence 8,6,4,2,8,6,...; no done; halt -> out_valid=0 next cycle, state IDLE.
- Up run 0..6, out_ready toggled 1,0,0,1,... -> out_value holds during ready=0 stalls; no value skipped or duplicated; xfer_cnt=4 at done.
- start with lo=10, hi=4 -> err=1 for one cycle; out_valid stays 0; busy stays 0.
- rst=1 asserted while in RUN with out_value=6 -> next cycle: all outputs 0, state IDLE; a subsequent start runs normally from the latched-after-start config.
- lo=hi=6, wrap=0 -> exactly one transfer of 6, then done. Separately, halt and out_ready in the same cycle -> xfer_cnt includes that transfer and done is not pulsed.
